// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - requester, divisor-port and uart_tx signal bundle for uart_tx_sched
interface uart_tx_sched_if #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic              cfg_valid;
    logic [12:0]       cfg_div;
    logic              cfg_ack;
    logic [12:0]       tx_data;
    logic              tx_send;
    logic              tx_set;
    logic              tx_busy;
    logic              active;
    logic [IDXW-1:0]   owner;
    logic              err;

    modport master (
        output req, req_data, cfg_valid, cfg_div, tx_busy,
        input  ack, cfg_ack, tx_data, tx_send, tx_set, active, owner, err
    );

    modport slave (
        input  req, req_data, cfg_valid, cfg_div, tx_busy,
        output ack, cfg_ack, tx_data, tx_send, tx_set, active, owner, err
    );
endinterface

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - shares one uart_tx among NREQ byte requesters and a divisor port
// UART_SCHED_RR_EN selects round-robin arbitration; otherwise the lowest index wins.
module uart_tx_sched #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input logic            clk,
    input logic            reset_n,
    uart_tx_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CFG, LAUNCH, WAIT_BUSY, DRAIN} state_t;

    state_t          state, next_state;
    logic            wait_cnt, wait_cnt_nxt;
    logic            any_req;
    logic [IDXW-1:0] win;
    logic [7:0]      req_byte [NREQ];

    logic [NREQ-1:0] ack_nxt;
    logic [12:0]     tx_data_nxt;
    logic [IDXW-1:0] owner_nxt;
    logic            cfg_ack_nxt, tx_send_nxt, tx_set_nxt, active_nxt, err_nxt;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_byte[i] = bus.req_data[8*i +: 8];
        end
    end

`ifdef UART_SCHED_RR_EN
    logic [IDXW-1:0] rr_ptr;

    // Pointer moves only on an actual grant; withdrawn requests leave it alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= IDXW'(NREQ - 1);
        end else if (state == IDLE && next_state == LAUNCH) begin
            rr_ptr <= win;
        end
    end

    always_comb begin : rr_arb
        logic [IDXW-1:0] j;
        any_req = 1'b0;
        win     = '0;
        j       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = IDXW'((int'(rr_ptr) + k) % NREQ);
            if (!any_req && bus.req[j]) begin
                any_req = 1'b1;
                win     = j;
            end
        end
    end
`else
    always_comb begin : fp_arb
        logic [IDXW-1:0] j;
        any_req = |bus.req;
        win     = '0;
        j       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = IDXW'(k);
            if (bus.req[j]) begin
                win = j;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wait_cnt    <= 1'b0;
            bus.ack     <= '0;
            bus.cfg_ack <= 1'b0;
            bus.tx_send <= 1'b0;
            bus.tx_set  <= 1'b0;
            bus.active  <= 1'b0;
            bus.err     <= 1'b0;
            bus.owner   <= '0;
            bus.tx_data <= 13'h0;
        end else begin
            state       <= next_state;
            wait_cnt    <= wait_cnt_nxt;
            bus.ack     <= ack_nxt;
            bus.cfg_ack <= cfg_ack_nxt;
            bus.tx_send <= tx_send_nxt;
            bus.tx_set  <= tx_set_nxt;
            bus.active  <= active_nxt;
            bus.err     <= err_nxt;
            bus.owner   <= owner_nxt;
            bus.tx_data <= tx_data_nxt;
        end
    end

    // A pending divisor update always beats byte requests, and nothing starts while busy.
    always_comb begin
        next_state   = state;
        wait_cnt_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.tx_busy) begin
                    if (bus.cfg_valid)  next_state = CFG;
                    else if (any_req)   next_state = LAUNCH;
                end
            end
            CFG:       next_state = IDLE;
            LAUNCH:    next_state = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.tx_busy)   next_state = DRAIN;
                else if (wait_cnt) next_state = IDLE;
                else               wait_cnt_nxt = 1'b1;
            end
            DRAIN:     if (!bus.tx_busy) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        tx_send_nxt = (next_state == LAUNCH);
        tx_set_nxt  = (next_state == CFG);
        cfg_ack_nxt = (next_state == CFG);
        active_nxt  = (next_state inside {LAUNCH, WAIT_BUSY, DRAIN});
        err_nxt     = (state == WAIT_BUSY) && (next_state == IDLE);
        ack_nxt     = '0;
        owner_nxt   = bus.owner;
        tx_data_nxt = bus.tx_data;
        if (state == IDLE && next_state == CFG) begin
            tx_data_nxt = bus.cfg_div;
        end
        if (state == IDLE && next_state == LAUNCH) begin
            ack_nxt[win] = 1'b1;
            owner_nxt    = win;
            tx_data_nxt  = {5'b0, req_byte[win]};
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed table-driven bench for uart_tx_sched (either UART_SCHED_RR_EN setting)
module tb_uart_tx_sched;
    localparam int NREQ     = 4;
    localparam int BUSY_LEN = 4;
`ifdef UART_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   busy_auto = 1'b1;
    int   bcnt;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   n_viol = 0;

    uart_tx_sched_if #(.NREQ(NREQ)) b ();
    uart_tx_sched #(.NREQ(NREQ)) dut (.clk(clk), .reset_n(rst_n), .bus(b.slave));

    always #5 clk = ~clk;

    // Stand-in for uart_tx: busy rises at the edge ending LAUNCH and lasts BUSY_LEN cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b.tx_busy <= 1'b0;
            bcnt      <= 0;
        end else if (busy_auto && b.tx_send) begin
            b.tx_busy <= 1'b1;
            bcnt      <= BUSY_LEN;
        end else if (bcnt > 1) begin
            bcnt <= bcnt - 1;
        end else if (bcnt == 1) begin
            bcnt      <= 0;
            b.tx_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && ((b.tx_set && b.tx_busy) || (b.tx_set && b.tx_send) || (b.tx_send && b.tx_busy)))
            n_viol <= n_viol + 1;
    end

    typedef struct {
        bit          is_cfg;
        logic [3:0]  req;
        logic [31:0] rdata;
        logic [12:0] div;
        logic [1:0]  own_rr;
        logic [1:0]  own_fp;
    } vec_t;

    vec_t vt [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [31:0] d, input bit cv, input logic [12:0] cd);
        b.req       = r;
        b.req_data  = d;
        b.cfg_valid = cv;
        b.cfg_div   = cd;
    endtask

    task automatic wait_evt(input string name, input bit want_set);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(want_set ? b.tx_set : b.tx_send) && k < 60);
        if (!(want_set ? b.tx_set : b.tx_send)) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: timeout, got no strobe, expected %s", name, want_set ? "tx_set" : "tx_send");
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((b.active || b.tx_busy || b.tx_set || b.tx_send) && k < 60);
        if (b.active || b.tx_busy || b.tx_set || b.tx_send) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: timeout, scheduler still active, expected idle", name);
        end
    endtask

    initial begin
        logic [1:0]  own;
        logic [31:0] sh;
        logic [12:0] ed;
        logic [1:0]  seq_rr [5];
        logic [1:0]  e_rr [3];
        int          gap, k, n_ack3;

        vt[0] = '{1'b1, 4'b0000, 32'h0000_0000, 13'h0004, 2'd0, 2'd0};
        vt[1] = '{1'b0, 4'b0001, 32'h0000_00A5, 13'h0000, 2'd0, 2'd0};
        vt[2] = '{1'b0, 4'b1111, 32'h4433_2211, 13'h0000, 2'd1, 2'd0};
        vt[3] = '{1'b0, 4'b1001, 32'h6600_0055, 13'h0000, 2'd3, 2'd0};
        vt[4] = '{1'b1, 4'b0000, 32'h0000_0000, 13'h1FFF, 2'd0, 2'd0};
        vt[5] = '{1'b0, 4'b0110, 32'h0088_7700, 13'h0000, 2'd1, 2'd1};
        vt[6] = '{1'b0, 4'b1000, 32'h9900_0000, 13'h0000, 2'd3, 2'd3};
        vt[7] = '{1'b0, 4'b0101, 32'h00BB_00AA, 13'h0000, 2'd0, 2'd0};
        vt[8] = '{1'b0, 4'b1110, 32'hFFEE_DDCC, 13'h0000, 2'd1, 2'd1};
        vt[9] = '{1'b1, 4'b0000, 32'h0000_0000, 13'h0000, 2'd0, 2'd0};
        seq_rr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        e_rr   = '{2'd3, 2'd1, 2'd3};

        drive(4'b0, 32'h0, 1'b0, 13'h0);
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(b.ack), 32'h0);
        check("rst_tx_send", 32'(b.tx_send), 32'h0);
        check("rst_tx_set", 32'(b.tx_set), 32'h0);
        check("rst_active", 32'(b.active), 32'h0);
        check("rst_tx_data", 32'(b.tx_data), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            own = RR ? vt[i].own_rr : vt[i].own_fp;
            sh  = vt[i].rdata >> (8 * own);
            ed  = vt[i].is_cfg ? vt[i].div : {5'b0, sh[7:0]};
            drive(vt[i].req, vt[i].rdata, vt[i].is_cfg, vt[i].div);
            wait_evt($sformatf("v%0d_strobe", i), vt[i].is_cfg);
            check($sformatf("v%0d_tx_data", i), 32'(b.tx_data), 32'(ed));
            check($sformatf("v%0d_tx_set", i), 32'(b.tx_set), 32'(vt[i].is_cfg));
            check($sformatf("v%0d_cfg_ack", i), 32'(b.cfg_ack), 32'(vt[i].is_cfg));
            check($sformatf("v%0d_tx_send", i), 32'(b.tx_send), 32'(!vt[i].is_cfg));
            check($sformatf("v%0d_ack", i), 32'(b.ack), vt[i].is_cfg ? 32'h0 : (32'h1 << own));
            if (!vt[i].is_cfg) check($sformatf("v%0d_owner", i), 32'(b.owner), 32'(own));
            drive(4'b0, 32'h0, 1'b0, 13'h0);
            wait_idle($sformatf("v%0d_idle", i));
        end

        // All four requesting continuously from a fresh pointer.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1111, 32'h4433_2211, 1'b0, 13'h0);
        for (int g = 0; g < 5; g++) begin
            gap = 0;
            k   = 0;
            do begin
                @(negedge clk);
                k++;
                if (!b.tx_busy && !b.tx_send) gap++;
            end while (!b.tx_send && k < 60);
            own = RR ? seq_rr[g] : 2'd0;
            sh  = 32'h4433_2211 >> (8 * own);
            check($sformatf("rr%0d_send", g), 32'(b.tx_send), 32'h1);
            check($sformatf("rr%0d_owner", g), 32'(b.owner), 32'(own));
            check($sformatf("rr%0d_ack", g), 32'(b.ack), 32'h1 << own);
            check($sformatf("rr%0d_data", g), 32'(b.tx_data), 32'(sh[7:0]));
            if (g > 0) check($sformatf("rr%0d_gap", g), 32'(gap), 32'd2);
        end
        drive(4'b0, 32'h0, 1'b0, 13'h0);
        wait_idle("rr_idle");

        // Divisor update arriving mid-frame, with req[2] queued behind it.
        drive(4'b0001, 32'h0000_0001, 1'b0, 13'h0);
        wait_evt("mid_send", 1'b0);
        check("mid_owner0", 32'(b.owner), 32'd0);
        drive(4'b0100, 32'h005C_0000, 1'b1, 13'd7);
        wait_evt("mid_set", 1'b1);
        check("mid_set_busy", 32'(b.tx_busy), 32'h0);
        check("mid_set_active", 32'(b.active), 32'h0);
        check("mid_set_data", 32'(b.tx_data), 32'd7);
        drive(4'b0100, 32'h005C_0000, 1'b0, 13'h0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!b.tx_send && k < 10);
        check("mid_set_to_send", 32'(k), 32'd2);
        check("mid_owner2", 32'(b.owner), 32'd2);
        check("mid_data2", 32'(b.tx_data), 32'h5C);
        check("mid_ack2", 32'(b.ack), 32'h4);
        drive(4'b0, 32'h0, 1'b0, 13'h0);
        wait_idle("mid_idle");

        // uart_tx never reports busy: err after two WAIT_BUSY cycles.
        busy_auto = 1'b0;
        drive(4'b0010, 32'h0000_3C00, 1'b0, 13'h0);
        wait_evt("err_send", 1'b0);
        check("err_data", 32'(b.tx_data), 32'h3C);
        drive(4'b0, 32'h0, 1'b0, 13'h0);
        @(negedge clk);
        check("err_w1", 32'({b.err, b.active}), 32'b01);
        @(negedge clk);
        check("err_w2", 32'({b.err, b.active}), 32'b01);
        @(negedge clk);
        check("err_pulse", 32'({b.err, b.active}), 32'b10);
        @(negedge clk);
        check("err_clear", 32'(b.err), 32'h0);
        busy_auto = 1'b1;
        drive(4'b0001, 32'h0000_0077, 1'b0, 13'h0);
        wait_evt("err_next_send", 1'b0);
        check("err_next_owner", 32'(b.owner), 32'd0);
        check("err_next_data", 32'(b.tx_data), 32'h77);
        drive(4'b0, 32'h0, 1'b0, 13'h0);
        wait_idle("err_idle");

        // Asynchronous reset while draining a frame.
        drive(4'b1000, 32'h1200_0000, 1'b0, 13'h0);
        wait_evt("rd_send", 1'b0);
        drive(4'b0, 32'h0, 1'b0, 13'h0);
        repeat (2) @(negedge clk);
        check("rd_drain", 32'({b.active, b.tx_busy}), 32'b11);
        rst_n = 1'b0;
        #1;
        check("rd_outs", 32'({b.ack, b.cfg_ack, b.tx_send, b.tx_set, b.active, b.err}), 32'h0);
        check("rd_owner", 32'(b.owner), 32'h0);
        check("rd_tx_data", 32'(b.tx_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1010, 32'hAB00_CD00, 1'b0, 13'h0);
        wait_evt("rd_post_send", 1'b0);
        check("rd_post_owner", 32'(b.owner), 32'd1);
        check("rd_post_data", 32'(b.tx_data), 32'hCD);
        check("rd_post_ack", 32'(b.ack), 32'h2);
        drive(4'b0, 32'h0, 1'b0, 13'h0);
        wait_idle("rd_idle");

        // req[1] and req[3] held together.
        n_ack3 = 0;
        drive(4'b1010, 32'hAB00_CD00, 1'b0, 13'h0);
        for (int g = 0; g < 3; g++) begin
            wait_evt($sformatf("hold%0d_send", g), 1'b0);
            check($sformatf("hold%0d_owner", g), 32'(b.owner), RR ? 32'(e_rr[g]) : 32'd1);
            if (b.ack[3]) n_ack3++;
        end
        check("hold_ack3_count", 32'(n_ack3), RR ? 32'd2 : 32'd0);
        drive(4'b0, 32'h0, 1'b0, 13'h0);
        wait_idle("hold_idle");

        check("strobe_overlap", 32'(n_viol), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
